// File: rtl/cpu_run_monitor.sv
// Watches a CPU program run from start until it halts (end address or jump-to-self)
// or times out, then compares the probed values against golden values.
//
// state  | meaning
// IDLE   | after reset, outputs cleared, waiting for start
// RUN    | counting cycles and PC changes, watching for halt or timeout
// SETTLE | halt seen, giving the probed values time to settle
// CHECK  | one-cycle compare of probes against expected
// DONE   | results held until the next start
module cpu_run_monitor #(
  parameter int PC_W      = 32,
  parameter int DATA_W    = 32,
  parameter int N_PROBE   = 2,
  parameter int TIMEOUT   = 1000,
  parameter int STALL_LIM = 4,
  parameter int SETTLE    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [PC_W-1:0]           pc,
  input  logic [PC_W-1:0]           halt_pc,
  input  logic [N_PROBE*DATA_W-1:0] probe,
  input  logic [N_PROBE*DATA_W-1:0] expected,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout,
  output logic [N_PROBE-1:0]        mismatch,
  output logic [31:0]               cycle_cnt,
  output logic [31:0]               instr_cnt,
  output logic                      trace_valid,
  output logic [PC_W-1:0]           trace_pc
);
  localparam int STALL_W  = (STALL_LIM > 1) ? $clog2(STALL_LIM + 1) : 1;
  localparam int SETTLE_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     prev_pc_q;
  logic [STALL_W-1:0]  stall_q;
  logic [SETTLE_W-1:0] settle_q;
  logic                pc_chg;
  logic                halt_det;
  logic                tmo_det;
  logic [N_PROBE-1:0]  mismatch_d;

  assign pc_chg   = (pc != prev_pc_q);
  // STALL_LIM equal samples = the sample that set prev_pc plus STALL_LIM-1 unchanged cycles
  assign halt_det = (pc == halt_pc) || (!pc_chg && (int'(stall_q) + 1 >= STALL_LIM - 1));
  assign tmo_det  = (cycle_cnt == 32'(TIMEOUT - 1));

  // 4-state compare so an X or Z probe never reads as a match
  always_comb begin
    mismatch_d = '0;
    for (int i = 0; i < N_PROBE; i++)
      mismatch_d[i] = (probe[i*DATA_W +: DATA_W] !== expected[i*DATA_W +: DATA_W]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (halt_det)     state_d = (SETTLE == 0) ? S_CHECK : S_SETTLE;
        else if (tmo_det) state_d = S_DONE;
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (settle_q == '0) state_d = S_CHECK;
      end
      S_CHECK: begin
        busy    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_pc_q   <= '0;
      stall_q     <= '0;
      settle_q    <= '0;
      cycle_cnt   <= '0;
      instr_cnt   <= '0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      mismatch    <= '0;
      trace_valid <= 1'b0;
      trace_pc    <= '0;
    end else begin
      trace_valid <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            prev_pc_q <= pc;
            stall_q   <= '0;
            cycle_cnt <= '0;
            instr_cnt <= '0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            mismatch  <= '0;
          end
        end
        S_RUN: begin
          // the timeout cycle itself is not counted, leaving cycle_cnt at TIMEOUT-1
          if (!tmo_det && cycle_cnt != '1) cycle_cnt <= cycle_cnt + 32'd1;
          if (pc_chg) begin
            prev_pc_q <= pc;
            stall_q   <= '0;
            if (instr_cnt != '1) instr_cnt <= instr_cnt + 32'd1;
            // a change on the exit cycle is counted but not traced, so no pulse leaks out of RUN
            if (state_d == S_RUN) begin
              trace_valid <= 1'b1;
              trace_pc    <= pc;
            end
          end else if (int'(stall_q) < STALL_LIM) begin
            stall_q <= stall_q + STALL_W'(1);
          end
          if (!halt_det && tmo_det) timeout <= 1'b1;
          if (halt_det && SETTLE > 0) settle_q <= SETTLE_W'(SETTLE - 1);
        end
        S_SETTLE: begin
          if (settle_q != '0) settle_q <= settle_q - SETTLE_W'(1);
        end
        S_CHECK: begin
          mismatch <= mismatch_d;
          pass     <= (mismatch_d == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Randomized and directed bench for cpu_run_monitor against a sample-level run model.
module tb_cpu_run_monitor;
  localparam int PC_W = 16, DATA_W = 8, N_PROBE = 2;
  localparam int TIMEOUT = 10, STALL_LIM = 4, SETTLE = 2;
  localparam int SEQ_N = 24;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [PC_W-1:0] pc = '0, halt_pc = '0;
  logic [N_PROBE*DATA_W-1:0] probe = '0, expected = '0;
  logic busy, done, pass, timeout, trace_valid;
  logic [N_PROBE-1:0] mismatch;
  logic [31:0] cycle_cnt, instr_cnt;
  logic [PC_W-1:0] trace_pc;

  int n_checks = 0;
  int n_fail = 0;

  logic [PC_W-1:0] pc_seq [SEQ_N];
  int              o_latency, o_busy_bad;
  logic [PC_W-1:0] o_trace [$];
  int              m_exit, m_latency;
  logic            m_timeout, m_pass;
  logic [N_PROBE-1:0] m_mismatch;
  logic [31:0]     m_cycle, m_instr;
  logic [PC_W-1:0] m_trace [$];

  always #5 clk = ~clk;

  cpu_run_monitor #(
    .PC_W(PC_W), .DATA_W(DATA_W), .N_PROBE(N_PROBE),
    .TIMEOUT(TIMEOUT), .STALL_LIM(STALL_LIM), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc), .halt_pc(halt_pc),
    .probe(probe), .expected(expected), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .mismatch(mismatch), .cycle_cnt(cycle_cnt),
    .instr_cnt(instr_cnt), .trace_valid(trace_valid), .trace_pc(trace_pc)
  );

  // Run model: walks the PC samples one RUN cycle at a time, tracking the length of
  // the current run of equal samples rather than any counter in the design.
  task automatic model_run(input logic [PC_W-1:0] start_pc, input logic [PC_W-1:0] hpc);
    logic [PC_W-1:0] last;
    int run_len;
    bit halted, chg;
    last = start_pc; run_len = 1; halted = 0;
    m_instr = 0; m_trace.delete(); m_exit = TIMEOUT - 1;
    for (int k = 0; k < TIMEOUT; k++) begin
      chg = (pc_seq[k] != last);
      if (chg) begin m_instr++; run_len = 1; end
      else run_len++;
      halted = (pc_seq[k] == hpc) || (run_len >= STALL_LIM);
      if (halted || k == TIMEOUT - 1) begin m_exit = k; break; end
      if (chg) m_trace.push_back(pc_seq[k]);
      last = pc_seq[k];
    end
    m_timeout  = !halted;
    m_cycle    = 32'((m_exit + 1 < TIMEOUT - 1) ? m_exit + 1 : TIMEOUT - 1);
    m_latency  = halted ? m_exit + SETTLE + 1 : m_exit;
    m_mismatch = '0;
    if (halted)
      for (int i = 0; i < N_PROBE; i++)
        m_mismatch[i] = (probe[i*DATA_W +: DATA_W] !== expected[i*DATA_W +: DATA_W]);
    m_pass = halted && (m_mismatch == '0);
  endtask

  // Starts a run from the current pc_seq and records what the monitor shows until done.
  task automatic do_run(input logic [PC_W-1:0] start_pc, input logic [PC_W-1:0] hpc,
                        input bit poke_start);
    bit seen;
    @(negedge clk);
    halt_pc = hpc; pc = start_pc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    o_trace.delete(); o_latency = -1; o_busy_bad = 0; seen = 0;
    for (int j = 0; j < 40 && !seen; j++) begin
      pc    = pc_seq[(j < SEQ_N) ? j : SEQ_N - 1];
      start = poke_start;
      @(negedge clk);
      if (trace_valid) o_trace.push_back(trace_pc);
      if (busy !== !done) o_busy_bad++;
      if (done === 1'b1) begin seen = 1; o_latency = j; end
    end
    start = 1'b0;
  endtask

  task automatic set_program_end();
    for (int k = 0; k < SEQ_N; k++) pc_seq[k] = (k < 3) ? PC_W'((k + 1) * 4) : PC_W'(12);
  endtask

  task automatic set_counting(input logic [PC_W-1:0] base);
    for (int k = 0; k < SEQ_N; k++) pc_seq[k] = base + PC_W'((k + 1) * 4);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, pass, timeout, mismatch, trace_valid, cycle_cnt, instr_cnt, trace_pc} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b pass=%b tmo=%b mm=%b tv=%b cyc=%0d ins=%0d tpc=%h, required all zero",
               busy, done, pass, timeout, mismatch, trace_valid, cycle_cnt, instr_cnt, trace_pc);
    end
    reset = 1'b0;
    repeat (4) begin
      pc = PC_W'($urandom);
      @(negedge clk);
    end
    n_checks++;
    if ({busy, done, pass, timeout, mismatch, trace_valid, cycle_cnt, instr_cnt, trace_pc} !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b done=%b cyc=%0d ins=%0d tv=%b, required all zero",
               busy, done, cycle_cnt, instr_cnt, trace_valid);
    end
  endtask

  task automatic test_program_end();
    set_program_end();
    probe = 16'hA55A; expected = 16'hA55A;
    model_run(16'd0, 16'd12);
    do_run(16'd0, 16'd12, 1'b0);
    n_checks++;
    if (instr_cnt !== 32'd3) begin
      n_fail++; $display("FAIL prog_end_instr: got %0d, required 3", instr_cnt);
    end
    n_checks++;
    if (o_latency !== m_latency) begin
      n_fail++; $display("FAIL prog_end_latency: got %0d, required %0d", o_latency, m_latency);
    end
    n_checks++;
    if (pass !== 1'b1 || mismatch !== 2'b00 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL prog_end_result: pass=%b mm=%b tmo=%b, required 1 00 0", pass, mismatch, timeout);
    end
    n_checks++;
    if (cycle_cnt !== m_cycle) begin
      n_fail++; $display("FAIL prog_end_cycles: got %0d, required %0d", cycle_cnt, m_cycle);
    end
    n_checks++;
    if (o_trace.size() != 2 || o_trace[0] !== 16'd4 || o_trace[1] !== 16'd8) begin
      n_fail++; $display("FAIL prog_end_trace: got %0d entries, required 2 entries 4,8", o_trace.size());
    end
    repeat (3) begin
      pc = PC_W'($urandom);
      @(negedge clk);
      n_checks++;
      if (done !== 1'b1 || trace_valid !== 1'b0 || cycle_cnt !== m_cycle || instr_cnt !== m_instr || pass !== m_pass) begin
        n_fail++;
        $display("FAIL done_hold: done=%b tv=%b cyc=%0d ins=%0d pass=%b, required 1 0 %0d %0d %b",
                 done, trace_valid, cycle_cnt, instr_cnt, pass, m_cycle, m_instr, m_pass);
      end
    end
  endtask

  task automatic test_jump_to_self();
    for (int k = 0; k < SEQ_N; k++) pc_seq[k] = 16'h0020;
    probe = {8'd47, 8'd9}; expected = {8'd48, 8'd9};
    model_run(16'h0020, 16'h0FFC);
    do_run(16'h0020, 16'h0FFC, 1'b0);
    n_checks++;
    if (mismatch !== 2'b10 || pass !== 1'b0 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL self_jump_result: mm=%b pass=%b tmo=%b, required 10 0 0", mismatch, pass, timeout);
    end
    n_checks++;
    if (o_latency !== m_latency || instr_cnt !== 32'd0) begin
      n_fail++; $display("FAIL self_jump_timing: latency=%0d ins=%0d, required %0d 0", o_latency, instr_cnt, m_latency);
    end
  endtask

  task automatic test_timeout();
    set_counting(16'h0100);
    probe = 16'h1234; expected = 16'h4321;
    model_run(16'h0100, 16'hFFFF);
    do_run(16'h0100, 16'hFFFF, 1'b0);
    n_checks++;
    if (timeout !== 1'b1 || pass !== 1'b0 || mismatch !== 2'b00 || done !== 1'b1) begin
      n_fail++; $display("FAIL timeout_result: tmo=%b pass=%b mm=%b done=%b, required 1 0 00 1", timeout, pass, mismatch, done);
    end
    n_checks++;
    if (cycle_cnt !== 32'd9 || o_latency !== m_latency) begin
      n_fail++; $display("FAIL timeout_cycles: cyc=%0d latency=%0d, required 9 %0d", cycle_cnt, o_latency, m_latency);
    end
    n_checks++;
    if (instr_cnt !== m_instr || o_trace.size() != m_trace.size()) begin
      n_fail++; $display("FAIL timeout_instr: ins=%0d traces=%0d, required %0d %0d", instr_cnt, o_trace.size(), m_instr, m_trace.size());
    end
  endtask

  task automatic test_simultaneous();
    set_counting(16'h0200);
    probe = 16'h7788; expected = 16'h7788;
    model_run(16'h0200, pc_seq[TIMEOUT-1]);
    do_run(16'h0200, pc_seq[TIMEOUT-1], 1'b0);
    n_checks++;
    if (timeout !== 1'b0 || pass !== 1'b1) begin
      n_fail++; $display("FAIL simul_result: tmo=%b pass=%b, required 0 1", timeout, pass);
    end
    n_checks++;
    if (o_latency !== m_latency || cycle_cnt !== 32'd9) begin
      n_fail++; $display("FAIL simul_timing: latency=%0d cyc=%0d, required %0d 9", o_latency, cycle_cnt, m_latency);
    end
  endtask

  task automatic test_start_ignored();
    set_program_end();
    probe = 16'h0F0F; expected = 16'h0F0F;
    model_run(16'd0, 16'd12);
    do_run(16'd0, 16'd12, 1'b1);
    n_checks++;
    if (instr_cnt !== 32'd3 || o_latency !== m_latency || pass !== 1'b1 || o_busy_bad != 0) begin
      n_fail++;
      $display("FAIL start_ignored: ins=%0d latency=%0d pass=%b busy_bad=%0d, required 3 %0d 1 0",
               instr_cnt, o_latency, pass, o_busy_bad, m_latency);
    end
  endtask

  task automatic test_reset_mid_run();
    set_counting(16'h0300);
    @(negedge clk);
    halt_pc = 16'hFFFF; pc = 16'h0300; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      pc = pc_seq[j];
      @(negedge clk);
    end
    n_checks++;
    if (busy !== 1'b1 || instr_cnt !== 32'd3) begin
      n_fail++; $display("FAIL midrun_progress: busy=%b ins=%0d, required 1 3", busy, instr_cnt);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, pass, timeout, mismatch, trace_valid, cycle_cnt, instr_cnt, trace_pc} !== '0) begin
      n_fail++;
      $display("FAIL midrun_async_reset: busy=%b cyc=%0d ins=%0d tv=%b tpc=%h, required all zero",
               busy, cycle_cnt, instr_cnt, trace_valid, trace_pc);
    end
    @(negedge clk);
    reset = 1'b0;
    set_program_end();
    probe = 16'h3C3C; expected = 16'h3C3C;
    model_run(16'd0, 16'd12);
    do_run(16'd0, 16'd12, 1'b0);
    n_checks++;
    if (instr_cnt !== 32'd3 || pass !== 1'b1 || o_latency !== m_latency) begin
      n_fail++; $display("FAIL midrun_restart: ins=%0d pass=%b latency=%0d, required 3 1 %0d", instr_cnt, pass, o_latency, m_latency);
    end
  endtask

  task automatic test_x_probe();
    for (int k = 0; k < SEQ_N; k++) pc_seq[k] = 16'h0044;
    probe = {8'h5A, 8'hxx}; expected = {8'h5A, 8'h00};
    model_run(16'h0040, 16'h0044);
    do_run(16'h0040, 16'h0044, 1'b0);
    n_checks++;
    if (mismatch !== m_mismatch || pass !== m_pass) begin
      n_fail++; $display("FAIL x_probe: mm=%b pass=%b, required %b %b", mismatch, pass, m_mismatch, m_pass);
    end
  endtask

  task automatic test_back_to_back();
    logic [PC_W-1:0] cur, spc, hpc;
    bit trace_ok;
    for (int it = 0; it < 40; it++) begin
      spc = PC_W'($urandom_range(0, 3) * 4);
      cur = spc;
      for (int k = 0; k < SEQ_N; k++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: cur = cur + 16'd4;
          5, 6:          cur = PC_W'($urandom_range(0, 15) * 4);
          default:       ;
        endcase
        pc_seq[k] = cur;
      end
      hpc = ($urandom_range(0, 1) == 1) ? pc_seq[$urandom_range(0, TIMEOUT - 1)] : 16'hFFF0;
      probe    = N_PROBE*DATA_W'($urandom);
      expected = probe;
      for (int i = 0; i < N_PROBE; i++)
        if ($urandom_range(0, 1) == 1) expected[i*DATA_W + $urandom_range(0, DATA_W - 1)] ^= 1'b1;
      model_run(spc, hpc);
      do_run(spc, hpc, 1'($urandom_range(0, 1)));
      n_checks++;
      if (o_latency !== m_latency || o_busy_bad != 0) begin
        n_fail++; $display("FAIL rand_latency it=%0d: latency=%0d busy_bad=%0d, required %0d 0", it, o_latency, o_busy_bad, m_latency);
      end
      n_checks++;
      if (instr_cnt !== m_instr || cycle_cnt !== m_cycle) begin
        n_fail++; $display("FAIL rand_counts it=%0d: ins=%0d cyc=%0d, required %0d %0d", it, instr_cnt, cycle_cnt, m_instr, m_cycle);
      end
      n_checks++;
      if (timeout !== m_timeout || pass !== m_pass || mismatch !== m_mismatch) begin
        n_fail++;
        $display("FAIL rand_result it=%0d: tmo=%b pass=%b mm=%b, required %b %b %b",
                 it, timeout, pass, mismatch, m_timeout, m_pass, m_mismatch);
      end
      trace_ok = (o_trace.size() == m_trace.size());
      if (trace_ok)
        for (int t = 0; t < o_trace.size(); t++) if (o_trace[t] !== m_trace[t]) trace_ok = 0;
      n_checks++;
      if (!trace_ok) begin
        n_fail++; $display("FAIL rand_trace it=%0d: %0d entries seen, required %0d matching entries", it, o_trace.size(), m_trace.size());
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_program_end();
    test_jump_to_self();
    test_timeout();
    test_simultaneous();
    test_start_ignored();
    test_reset_mid_run();
    test_x_probe();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
